// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: instruction-memory request/response, redirect, and decode handshake.
// master = fetch_queue side, slave = memory/decode/execute side.
interface fetch_queue_if;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_ir;

  modport master (
    output imem_en, imem_addr, out_valid, out_pc, out_ir,
    input  imem_data, redirect, redirect_addr, out_ready
  );

  modport slave (
    input  imem_en, imem_addr, out_valid, out_pc, out_ir,
    output imem_data, redirect, redirect_addr, out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch stage with a DEPTH-entry {PC, IR} prefetch FIFO and redirect flush.
// Optional macro FETCHQ_BYPASS_EN: empty-queue responses go straight to the output.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic          clk,
  input logic          resetn,
  fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic [31:0]   f_pc, req_pc;
  logic          inflight;

  logic          push, pop, head_vld, bypass, wr_en, rd_en;
  logic [AW+1:0] occ;
  entry_t        head;
  logic          unused_addr_bits;

  assign unused_addr_bits = &{1'b0, bus.redirect_addr[1:0]};

  assign push     = inflight & ~bus.redirect;
  assign head_vld = (count != '0);

`ifdef FETCHQ_BYPASS_EN
  assign bypass = ~head_vld & push;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    head = '0;
    if (head_vld)    head = mem[rd_ptr];
    else if (bypass) head = '{pc: req_pc, ir: bus.imem_data};
  end

  assign bus.out_valid = head_vld | bypass;
  assign bus.out_pc    = head.pc;
  assign bus.out_ir    = head.ir;

  assign pop   = bus.out_valid & bus.out_ready;
  // A bypassed entry consumed in the same cycle never touches the FIFO.
  assign wr_en = push & ~(bypass & bus.out_ready);
  assign rd_en = pop & head_vld;

  // Credit: slots committed after this edge, counting the in-flight response.
  assign occ          = {1'b0, count} + (AW+2)'(inflight) - (AW+2)'(pop);
  assign bus.imem_en  = resetn & ~bus.redirect & (occ < (AW+2)'(DEPTH));
  assign bus.imem_addr = f_pc;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= '{pc: req_pc, ir: bus.imem_data};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      f_pc     <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (bus.redirect) begin
      f_pc     <= {bus.redirect_addr[31:2], 2'b00};
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count    <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
      inflight <= bus.imem_en;
      if (bus.imem_en) begin
        f_pc   <= f_pc + 32'd4;
        req_pc <= f_pc;
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: cycle table on a DEPTH=4 instance plus
// backpressure, redirect-latency and DEPTH=2 random-ready streaming sequences.
module tb_fetch_queue;
`ifdef FETCHQ_BYPASS_EN
  localparam int LAT = 1, RLAT = 2;
`else
  localparam int LAT = 2, RLAT = 3;
`endif

  logic clk = 1'b0;
  logic resetn, rst2_n;
  always #5 clk = ~clk;

  fetch_queue_if b4();
  fetch_queue_if b2();

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0))       u4 (.clk(clk), .resetn(resetn), .bus(b4));
  fetch_queue #(.DEPTH(2), .RESET_PC(32'h0000_1000)) u2 (.clk(clk), .resetn(rst2_n), .bus(b2));

  function automatic logic [31:0] mk(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // one-cycle synchronous instruction memories; data holds when not enabled
  logic [31:0] m4_q = 32'hBAD0_BAD0, m2_q = 32'hBAD0_BAD0;
  always @(posedge clk) if (b4.imem_en) m4_q <= mk(b4.imem_addr);
  always @(posedge clk) if (b2.imem_en) m2_q <= mk(b2.imem_addr);
  assign b4.imem_data = m4_q;
  assign b2.imem_data = m2_q;

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rstn;
    logic        redir;
    logic [31:0] raddr;
    logic        rdy;
    logic        en;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  vec_t tv[$];

  function automatic void v(logic rstn, logic redir, logic [31:0] raddr, logic rdy,
                            logic en, logic [31:0] addr, logic vld, logic [31:0] pc);
    vec_t t;
    t = '{rstn, redir, raddr, rdy, en, addr, vld, pc};
    tv.push_back(t);
  endfunction

  initial begin
    int reqs, first_v, pops, cyc, occ;
    logic [31:0] exp_pc;
    logic en_last, push, pop, seen;

    resetn = 1'b0; rst2_n = 1'b0;
    b4.redirect = 1'b0; b4.redirect_addr = '0; b4.out_ready = 1'b0;
    b2.redirect = 1'b0; b2.redirect_addr = '0; b2.out_ready = 1'b0;

    //  rstn redir raddr        rdy  en  addr          vld pc
    v(0, 0, 32'h0,        1,   0, 32'h0,        0, 32'h0);
    v(1, 0, 32'h0,        1,   1, 32'h0,        0, 32'h0);
    v(1, 0, 32'h0,        1,   1, 32'h4,        0, 32'h0);
    v(1, 0, 32'h0,        1,   1, 32'h8,        1, 32'h0);
    v(1, 0, 32'h0,        1,   1, 32'hC,        1, 32'h4);
    v(1, 0, 32'h0,        1,   1, 32'h10,       1, 32'h8);
    v(1, 0, 32'h0,        0,   1, 32'h14,       1, 32'hC);
    v(1, 0, 32'h0,        0,   1, 32'h18,       1, 32'hC);
    v(1, 0, 32'h0,        0,   0, 32'h1C,       1, 32'hC);
    v(1, 0, 32'h0,        0,   0, 32'h1C,       1, 32'hC);
    v(1, 0, 32'h0,        1,   1, 32'h1C,       1, 32'hC);
    v(1, 0, 32'h0,        1,   1, 32'h20,       1, 32'h10);
    v(1, 0, 32'h0,        0,   0, 32'h24,       1, 32'h14);
    v(1, 0, 32'h0,        1,   1, 32'h24,       1, 32'h14);
    v(1, 1, 32'h105,      0,   0, 32'h28,       1, 32'h18);
    v(1, 0, 32'h0,        1,   1, 32'h104,      0, 32'h0);
    v(1, 0, 32'h0,        1,   1, 32'h108,      0, 32'h0);
    v(1, 0, 32'h0,        1,   1, 32'h10C,      1, 32'h104);
    v(1, 1, 32'h200,      1,   0, 32'h110,      1, 32'h108);
    v(1, 0, 32'h0,        1,   1, 32'h200,      0, 32'h0);
    v(1, 0, 32'h0,        1,   1, 32'h204,      0, 32'h0);
    v(1, 0, 32'h0,        1,   1, 32'h208,      1, 32'h200);
    v(1, 0, 32'h0,        0,   1, 32'h20C,      1, 32'h204);
    v(0, 0, 32'h0,        0,   0, 32'h0,        0, 32'h0);
    v(1, 0, 32'h0,        1,   1, 32'h0,        0, 32'h0);
    v(1, 0, 32'h0,        1,   1, 32'h4,        0, 32'h0);
    v(1, 0, 32'h0,        1,   1, 32'h8,        1, 32'h0);
    v(1, 1, 32'hFFFF_FFFE, 1,  0, 32'hC,        1, 32'h4);
    v(1, 0, 32'h0,        1,   1, 32'hFFFF_FFFC, 0, 32'h0);
    v(1, 0, 32'h0,        1,   1, 32'h0,        0, 32'h0);
    v(1, 0, 32'h0,        1,   1, 32'h4,        1, 32'hFFFF_FFFC);
    v(1, 0, 32'h0,        1,   1, 32'h8,        1, 32'h0);

    @(posedge clk); #1;

`ifndef FETCHQ_BYPASS_EN
    // cycle-exact table (FIFO-only timing)
    for (int i = 0; i < tv.size(); i++) begin
      resetn = tv[i].rstn;
      b4.redirect = tv[i].redir;
      b4.redirect_addr = tv[i].raddr;
      b4.out_ready = tv[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d_en", i),   {31'b0, b4.imem_en},   {31'b0, tv[i].en});
      chk($sformatf("v%0d_addr", i), b4.imem_addr,          tv[i].addr);
      chk($sformatf("v%0d_vld", i),  {31'b0, b4.out_valid}, {31'b0, tv[i].vld});
      chk($sformatf("v%0d_pc", i),   b4.out_pc,             tv[i].pc);
      chk($sformatf("v%0d_ir", i),   b4.out_ir,             tv[i].vld ? mk(tv[i].pc) : 32'h0);
      @(posedge clk); #1;
    end
    b4.redirect = 1'b0;
`endif

    // backpressure from reset: exactly DEPTH requests, then gap-free drain
    resetn = 1'b0; b4.out_ready = 1'b0;
    @(negedge clk);
    chk("rst_en",  {31'b0, b4.imem_en},   32'h0);
    chk("rst_vld", {31'b0, b4.out_valid}, 32'h0);
    chk("rst_addr", b4.imem_addr, 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;
    reqs = 0; first_v = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (b4.imem_en) begin
        chk($sformatf("bp_addr%0d", reqs), b4.imem_addr, 32'(reqs * 4));
        reqs++;
      end
      if (b4.out_valid && first_v < 0) first_v = c;
      @(posedge clk); #1;
    end
    chk("bp_req_count", reqs, 4);
    chk("first_valid_lat", first_v, LAT);
    @(negedge clk);
    chk("bp_en_low", {31'b0, b4.imem_en}, 32'h0);
    @(posedge clk); #1;
    b4.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("drain_vld%0d", k), {31'b0, b4.out_valid}, 32'h1);
      chk($sformatf("drain_pc%0d", k),  b4.out_pc, 32'(k * 4));
      chk($sformatf("drain_ir%0d", k),  b4.out_ir, mk(32'(k * 4)));
      @(posedge clk); #1;
    end

    // redirect together with a pop: first valid must be the target, at RLAT
    b4.redirect = 1'b1; b4.redirect_addr = 32'h0000_0302;
    @(negedge clk);
    chk("redir_en_low", {31'b0, b4.imem_en}, 32'h0);
    @(posedge clk); #1;
    b4.redirect = 1'b0;
    seen = 1'b0;
    for (int c = 1; c <= 4 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) chk("redir_addr", b4.imem_addr, 32'h300);
      if (b4.out_valid) begin
        seen = 1'b1;
        chk("redir_pc", b4.out_pc, 32'h300);
        chk("redir_lat", c, RLAT);
      end
      @(posedge clk); #1;
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL redir_timeout: got no valid want pc 00000300");
    end

    // DEPTH=2 stream with random ready: strict order, no loss, no overflow
    rst2_n = 1'b1;
    exp_pc = 32'h0000_1000; pops = 0; cyc = 0; occ = 0; en_last = 1'b0;
    while (pops < 100 && cyc < 3000) begin
      b2.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      push = en_last;
      pop  = b2.out_valid & b2.out_ready;
      if (push) chk("d2_overflow", {31'b0, (occ == 2) && !pop}, 32'h0);
      if (pop) begin
        chk($sformatf("d2_pc%0d", pops), b2.out_pc, exp_pc);
        chk($sformatf("d2_ir%0d", pops), b2.out_ir, mk(exp_pc));
        exp_pc += 32'd4;
        pops++;
      end
      occ = occ + int'(push) - int'(pop);
      en_last = b2.imem_en;
      cyc++;
      @(posedge clk); #1;
    end
    chk("d2_stream_done", pops, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
